// File: rtl/bcd_display_scan.sv
// bcd_display_scan
//   Time-multiplexes NUM_DIGITS packed BCD digits onto one shared 7-segment bus.
//   All digits are captured into a shadow register once per frame, when the scan
//   wraps back to digit 0, so a count that changes mid-frame never tears.
//   After every digit switch the anodes are held dark for BLANK_CYCLES cycles to
//   avoid ghosting of the previous digit's segments.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   bcd_in       packed BCD, digit k = bcd_in[4k+3:4k], digit 0 least significant
//   dp_in        decimal point request per digit, active high
//   seg          segments {g,f,e,d,c,b,a}, active low, registered
//   dp           decimal point, active low, registered
//   an           digit enables, active low, at most one low
//   frame_start  one-cycle pulse after a new snapshot has been taken
module bcd_display_scan #(
  parameter int NUM_DIGITS   = 3,
  parameter int CLK_HZ       = 100000000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int DIV     = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W   = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;  // non-BCD code shows a dash
    endcase
  endfunction

  function automatic logic [NUM_DIGITS-1:0] digit_enable(input logic [IDX_W-1:0] i);
    digit_enable = {NUM_DIGITS{1'b1}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (i == IDX_W'(k)) digit_enable[k] = 1'b0;
    end
  endfunction

  logic [PRESC_W-1:0]      presc;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_next;
  logic [CNT_W-1:0]        blank_cnt;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    tick_p0;
  logic                    vld_p1;
  logic [3:0]              cur_bcd;
  logic                    cur_dp;
  logic                    cur_lz;
  logic                    zero_above;

  // Stage p0: prescaler tick and next digit index
  assign tick_p0  = (presc == PRESC_W'(DIV - 1));
  assign idx_next = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);

  // Selected shadow digit; a digit is a leading zero when it and every
  // higher digit are 0 (a dash code is non-zero, so it stops the run).
  always_comb begin
    cur_bcd    = '0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (shadow_bcd[4*k +: 4] == 4'd0);
      if (idx == IDX_W'(k)) begin
        cur_bcd = shadow_bcd[4*k +: 4];
        cur_dp  = shadow_dp[k];
        cur_lz  = zero_above && (k != 0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc       <= '0;
      idx         <= IDX_W'(NUM_DIGITS - 1);
      blank_cnt   <= '0;
      shadow_bcd  <= '0;
      shadow_dp   <= '0;
      vld_p1      <= 1'b0;
      frame_start <= 1'b0;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      an          <= {NUM_DIGITS{1'b1}};
    end else begin
      presc       <= tick_p0 ? '0 : presc + PRESC_W'(1);
      vld_p1      <= tick_p0;
      frame_start <= tick_p0 && (idx_next == '0);

      if (tick_p0) begin
        idx       <= idx_next;
        blank_cnt <= CNT_W'(BLANK_CYCLES);
        if (idx_next == '0) begin
          shadow_bcd <= bcd_in;
          shadow_dp  <= dp_in;
        end
      end else if (!vld_p1 && blank_cnt != '0) begin
        // dead-time count starts after the edge that loads seg
        blank_cnt <= blank_cnt - CNT_W'(1);
      end

      // Stage p1: present the new digit, anodes follow after the dead time
      if (vld_p1) begin
        seg <= (LZ_BLANK && cur_lz) ? 7'h7F : decode(cur_bcd);
        dp  <= ~cur_dp;
        an  <= (BLANK_CYCLES > 0) ? {NUM_DIGITS{1'b1}} : digit_enable(idx);
      end else if (blank_cnt == CNT_W'(1)) begin
        an <= digit_enable(idx);
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan
//   Drives two instances (leading-zero blanking on and off) with directed and
//   random BCD traffic. A reference model derives each cycle's expected outputs
//   from the frame arithmetic (tick every DIV cycles, snapshot when the scan
//   wraps to digit 0) and queues them; a monitor pops and compares every cycle.
module tb_bcd_display_scan;

  localparam int ND      = 3;
  localparam int CLK_HZ  = 1200;
  localparam int REF_HZ  = 100;
  localparam int BLANK   = 1;
  localparam int DIV     = CLK_HZ / (REF_HZ * ND);

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [11:0]   bcd = 12'h159;
  logic [2:0]    dpi = 3'b000;
  logic [6:0]    seg_a, seg_b;
  logic          dp_a, dp_b;
  logic [2:0]    an_a, an_b;
  logic          fs_a, fs_b;

  int passed = 0;
  int total  = 0;

  bcd_display_scan #(.NUM_DIGITS(ND), .CLK_HZ(CLK_HZ), .REFRESH_HZ(REF_HZ),
                     .BLANK_CYCLES(BLANK), .LZ_BLANK(1'b1)) dut_lz (
    .clk(clk), .reset(reset), .bcd_in(bcd), .dp_in(dpi),
    .seg(seg_a), .dp(dp_a), .an(an_a), .frame_start(fs_a));

  bcd_display_scan #(.NUM_DIGITS(ND), .CLK_HZ(CLK_HZ), .REFRESH_HZ(REF_HZ),
                     .BLANK_CYCLES(BLANK), .LZ_BLANK(1'b0)) dut_nolz (
    .clk(clk), .reset(reset), .bcd_in(bcd), .dp_in(dpi),
    .seg(seg_b), .dp(dp_b), .an(an_b), .frame_start(fs_b));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic [2:0] an;
    logic [6:0] seg1;
    logic [6:0] seg0;
    logic       dp;
    logic       fs;
  } rec_t;

  rec_t sb[$];

  // Reference model state
  int         m = 0;
  bit         shown_valid = 0;
  int         shown_idx = 0;
  logic [6:0] shown_seg1, shown_seg0;
  logic       shown_dp;
  logic [11:0] snap = '0;
  logic [2:0]  snap_dp = '0;

  always @(posedge clk) begin
    rec_t r;
    if (!reset) begin
      m = 0;
      shown_valid = 0;
      snap = '0;
      snap_dp = '0;
      sb.delete();
    end else begin
      m++;
      r.fs = (m % DIV == 0) && (((m / DIV) - 1) % ND == 0);
      if (!shown_valid) begin
        r.an = 3'b111; r.seg1 = 7'h7F; r.seg0 = 7'h7F; r.dp = 1'b1;
      end else begin
        r.an   = (((m - 1) % DIV) < BLANK) ? 3'b111 : ~(3'b001 << shown_idx);
        r.seg1 = shown_seg1;
        r.seg0 = shown_seg0;
        r.dp   = shown_dp;
      end
      sb.push_back(r);
      if (m % DIV == 0) begin
        shown_idx = ((m / DIV) - 1) % ND;
        if (shown_idx == 0) begin
          snap    = bcd;
          snap_dp = dpi;
        end
        shown_valid = 1;
        shown_seg0  = SEG_TAB[(snap >> (4 * shown_idx)) & 12'hF];
        shown_seg1  = (shown_idx > 0 && (snap >> (4 * shown_idx)) == 0) ? 7'h7F : shown_seg0;
        shown_dp    = ~snap_dp[shown_idx];
      end
    end
  end

  // Monitor: one queued record per clock while out of reset
  always @(negedge clk) begin
    rec_t e;
    if (reset) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 0, 1);
      end else begin
        e = sb.pop_front();
        check("an_lz",    an_a,  e.an);
        check("an_nolz",  an_b,  e.an);
        check("seg_lz",   seg_a, e.seg1);
        check("seg_nolz", seg_b, e.seg0);
        check("dp_lz",    dp_a,  e.dp);
        check("dp_nolz",  dp_b,  e.dp);
        check("fs_lz",    fs_a,  e.fs);
        check("fs_nolz",  fs_b,  e.fs);
        check("an_onehot", ($countones(~an_a) <= 1), 1);
      end
    end
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_an(input logic [2:0] v);
    bit found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      #1;
      if (an_a == v) found = 1;
    end
    check("wait_an", found, 1);
  endtask

  task automatic check_dark(input string tag);
    check({tag, "_seg_lz"},   seg_a, 7'h7F);
    check({tag, "_seg_nolz"}, seg_b, 7'h7F);
    check({tag, "_dp"},       dp_a,  1'b1);
    check({tag, "_an"},       an_a,  3'b111);
    check({tag, "_an_nolz"},  an_b,  3'b111);
    check({tag, "_fs"},       fs_a,  1'b0);
  endtask

  initial begin
    logic [11:0] v;
    #1 reset = 1'b0;
    run(3);
    #1 check_dark("reset");
    #1 reset = 1'b1;

    // First frame of 159, then change to 160 while digit 1 is on
    wait_an(3'b101);
    bcd = 12'h160;
    run(30);

    // Leading zeros
    bcd = 12'h007;
    run(30);

    // Dash digit with decimal point
    bcd = 12'h0A3;
    dpi = 3'b010;
    run(30);

    // Random traffic, changes land at arbitrary points in the frame
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 4) == 0) begin
        v = '0;
        for (int d = 0; d < ND; d++) begin
          if ($urandom_range(0, 1) == 1) v[4*d +: 4] = 4'($urandom_range(0, 15));
        end
        bcd = v;
        dpi = 3'($urandom_range(0, 7));
      end
    end

    // Asynchronous reset in the middle of digit 1
    bcd = 12'h159;
    dpi = 3'b000;
    run(15);
    wait_an(3'b101);
    #1 reset = 1'b0;
    #1 check_dark("async_rst");
    run(3);
    #2 reset = 1'b1;
    run(40);

    #1 check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
